// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer shared types: FSM states, opcodes,
// instruction word fields and result flag positions.
package exec_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;

  localparam int OP_LSB = 0;
  localparam int OP_MSB = 3;
  localparam int A_LSB  = 8;
  localparam int A_MSB  = 15;
  localparam int B_LSB  = 16;
  localparam int B_MSB  = 23;

  // res_flags = {ovf, unf, err}
  localparam int FLAG_ERR = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_OVF = 2;

  function automatic logic [15:0] sext8(
    input logic [7:0] v
  );
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// exec_sequencer bus: program memory, mul/div
// unit handshake and result stream.
interface exec_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mul_en;
  logic              div_en;
  logic [7:0]        op_a;
  logic [7:0]        op_b;
  logic              mul_done;
  logic              div_done;
  logic [15:0]       mul_result;
  logic [15:0]       div_result;
  logic              res_valid;
  logic [ADDR_W-1:0] res_addr;
  logic [15:0]       res_data;
  logic [2:0]        res_flags;
  logic              busy;
  logic              done;

  modport master (
    input  start, first_addr, last_addr,
    input  mem_rdata,
    input  mul_done, div_done,
    input  mul_result, div_result,
    output mem_addr, mul_en, div_en,
    output op_a, op_b,
    output res_valid, res_addr,
    output res_data, res_flags,
    output busy, done
  );

  modport slave (
    output start, first_addr, last_addr,
    output mem_rdata,
    output mul_done, div_done,
    output mul_result, div_result,
    input  mem_addr, mul_en, div_en,
    input  op_a, op_b,
    input  res_valid, res_addr,
    input  res_data, res_flags,
    input  busy, done
  );
endinterface

// File: rtl/exec_sequencer_addsub.sv
// exec_addsub: 8-bit two's complement add/sub
// with overflow/underflow detection.
module exec_addsub (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  output logic [7:0] sum,
  output logic       ovf,
  output logic       unf
);
  logic [7:0] bx;

  assign bx  = sub ? ~b : b;
  assign sum = a + bx + {7'd0, sub};
  assign ovf = ~a[7] & ~bx[7] & sum[7];
  assign unf = a[7] & bx[7] & ~sum[7];
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: walks a program window, runs
// add/sub locally and mul/div on external units.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 5
) (
  input logic clk,
  input logic rst,
  exec_sequencer_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] ERR_FLAGS =
    3'(1 << FLAG_ERR);

  state_e            state;
  state_e            state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] last_q;
  logic [3:0]        op_q;
  logic [7:0]        a_q;
  logic [7:0]        b_q;
  logic [TW-1:0]     timer;
  logic [15:0]       data_q;
  logic [2:0]        flags_q;

  logic [3:0]  op_w;
  logic [7:0]  a_w;
  logic [7:0]  b_w;
  logic        is_as;
  logic        is_unit;
  logic [7:0]  sum;
  logic        ovf;
  logic        unf;
  logic [2:0]  as_flags;
  logic        unit_done;
  logic [15:0] unit_res;
  logic        timed_out;
  logic        unused_bits;

  assign op_w = bus.mem_rdata[OP_MSB:OP_LSB];
  assign a_w  = bus.mem_rdata[A_MSB:A_LSB];
  assign b_w  = bus.mem_rdata[B_MSB:B_LSB];
  assign unused_bits = ^{bus.mem_rdata[31:24],
                         bus.mem_rdata[7:4]};

  assign is_as   = (op_w == OP_ADD) |
                   (op_w == OP_SUB);
  assign is_unit = (op_w == OP_MUL) |
                   (op_w == OP_DIV);

  exec_addsub u_addsub (
    .a   (a_w),
    .b   (b_w),
    .sub (op_w == OP_SUB),
    .sum (sum),
    .ovf (ovf),
    .unf (unf)
  );

  always_comb begin
    as_flags = '0;
    as_flags[FLAG_OVF] = ovf;
    as_flags[FLAG_UNF] = unf;
  end

  // only the unit selected in DECODE may end WAIT
  assign unit_done = (op_q == OP_MUL) ?
                     bus.mul_done : bus.div_done;
  assign unit_res  = (op_q == OP_MUL) ?
                     bus.mul_result : bus.div_result;
  assign timed_out = timer == TW'(TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (bus.start) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = is_unit ? S_WAIT : S_EMIT;
      S_WAIT:
        if (unit_done || timed_out)
          state_nx = S_EMIT;
      S_EMIT:
        state_nx = (ptr == last_q) ?
                   S_DONE : S_FETCH;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      last_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      timer   <= '0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      unique case (state)
        S_IDLE:
          if (bus.start) begin
            ptr    <= bus.first_addr;
            last_q <= bus.last_addr;
          end
        S_DECODE: begin
          op_q  <= op_w;
          timer <= '0;
          unique case (1'b1)
            is_as: begin
              data_q  <= (ovf | unf) ?
                         16'd0 : sext8(sum);
              flags_q <= as_flags;
            end
            is_unit: begin
              a_q <= a_w;
              b_q <= b_w;
            end
            default: begin
              data_q  <= '0;
              flags_q <= ERR_FLAGS;
            end
          endcase
        end
        S_WAIT:
          if (unit_done) begin
            data_q  <= unit_res;
            flags_q <= '0;
          end else if (timed_out) begin
            data_q  <= '0;
            flags_q <= ERR_FLAGS;
          end else begin
            timer <= timer + TW'(1);
          end
        S_EMIT:
          if (ptr != last_q)
            ptr <= ptr + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  // state-decoded outputs fall with async reset
  always_comb begin
    bus.busy      = state != S_IDLE;
    bus.res_valid = state == S_EMIT;
    bus.done      = state == S_DONE;
    bus.mul_en    = (state == S_WAIT) &
                    (op_q == OP_MUL);
    bus.div_en    = (state == S_WAIT) &
                    (op_q == OP_DIV);
  end

  assign bus.mem_addr  = ptr;
  assign bus.res_addr  = ptr;
  assign bus.op_a      = a_q;
  assign bus.op_b      = b_q;
  assign bus.res_data  = data_q;
  assign bus.res_flags = flags_q;
endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a
// synchronous program memory and mul/div stubs.
module tb_exec_sequencer;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  logic [31:0] mem [32];
  logic [4:0]  got_addr  [8];
  logic [15:0] got_data  [8];
  logic [2:0]  got_flags [8];
  int          got_n;
  int          got_done;
  bit          got_to;
  bit          got_en;

  exec_sequencer_if #(.ADDR_W(5)) bus ();

  exec_sequencer #(
    .TIMEOUT (64),
    .ADDR_W  (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    bus.mem_rdata <= mem[bus.mem_addr];

  function automatic logic [31:0] w(
    input logic [3:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    return {8'h00, b, a, 4'h0, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(
    input logic [4:0] f,
    input logic [4:0] l
  );
    bus.first_addr = f;
    bus.last_addr  = l;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.first_addr = ~f;
    bus.last_addr  = ~l;
    got_n = 0;
    got_done = 0;
    got_to = 1'b1;
    got_en = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c == 1) bus.start = 1'b1;
      if (c == 2) bus.start = 1'b0;
      if (bus.mul_en || bus.div_en) got_en = 1'b1;
      if (bus.res_valid && got_n < 8) begin
        got_addr[got_n]  = bus.res_addr;
        got_data[got_n]  = bus.res_data;
        got_flags[got_n] = bus.res_flags;
        got_n++;
      end
      if (bus.done) got_done++;
      if (!bus.busy) begin
        got_to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl busy=%b done=%b valid=%b want 000", bus.busy, bus.done, bus.res_valid);
    end
    n_chk++;
    if (bus.mul_en !== 1'b0 || bus.div_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_en mul=%b div=%b want 00", bus.mul_en, bus.div_en);
    end
    n_chk++;
    if ({bus.mem_addr, bus.res_addr, bus.op_a, bus.op_b, bus.res_data, bus.res_flags} !== 45'd0) begin
      n_fail++;
      $display("FAIL reset_data addr=%h raddr=%h a=%h b=%h d=%h f=%b want 0", bus.mem_addr, bus.res_addr, bus.op_a, bus.op_b, bus.res_data, bus.res_flags);
    end
  endtask

  task automatic test_add_basic();
    mem[0] = w(4'd0, 8'h05, 8'h03);
    bus.first_addr = 5'd0;
    bus.last_addr  = 5'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_chk++;
    if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_c1 busy=%b valid=%b want 1 0", bus.busy, bus.res_valid);
    end
    tick();
    n_chk++;
    if (bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_c2 valid=%b want 0", bus.res_valid);
    end
    tick();
    n_chk++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0008 || bus.res_flags !== 3'b000 || bus.res_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL add_c3 valid=%b data=%h flags=%b addr=%0d want 1 0008 000 0", bus.res_valid, bus.res_data, bus.res_flags, bus.res_addr);
    end
    tick();
    n_chk++;
    if (bus.done !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_done done=%b valid=%b want 1 0", bus.done, bus.res_valid);
    end
    tick();
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL add_idle busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_flags();
    logic [15:0] ed [5];
    logic [2:0]  ef [5];
    mem[3] = w(4'd0, 8'h64, 8'h64);
    mem[4] = w(4'd1, 8'h80, 8'h01);
    mem[5] = w(4'd7, 8'h11, 8'h22);
    mem[6] = w(4'd1, 8'h05, 8'h07);
    mem[7] = w(4'd0, 8'h80, 8'hFF);
    ed = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 16'h0000};
    ef = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b010};
    run_window(5'd3, 5'd7);
    n_chk++;
    if (got_to !== 1'b0 || got_n !== 5 || got_done !== 1) begin
      n_fail++;
      $display("FAIL flags_run timeout=%b words=%0d dones=%0d want 0 5 1", got_to, got_n, got_done);
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (got_addr[i] !== 5'(3 + i) || got_data[i] !== ed[i] || got_flags[i] !== ef[i]) begin
        n_fail++;
        $display("FAIL flags_w%0d addr=%0d data=%h flags=%b want %0d %h %b", i, got_addr[i], got_data[i], got_flags[i], 3 + i, ed[i], ef[i]);
      end
    end
    n_chk++;
    if (got_en !== 1'b0) begin
      n_fail++;
      $display("FAIL flags_noen unit enabled=%b want 0", got_en);
    end
  endtask

  task automatic test_mul();
    mem[8] = w(4'd2, 8'h07, 8'hFD);
    bus.first_addr = 5'd8;
    bus.last_addr  = 5'd8;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    n_chk++;
    if (bus.mul_en !== 1'b1 || bus.div_en !== 1'b0 || bus.op_a !== 8'h07 || bus.op_b !== 8'hFD) begin
      n_fail++;
      $display("FAIL mul_issue mul=%b div=%b a=%h b=%h want 1 0 07 fd", bus.mul_en, bus.div_en, bus.op_a, bus.op_b);
    end
    bus.div_done = 1'b1;
    bus.div_result = 16'h1234;
    tick();
    bus.div_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (bus.mul_en !== 1'b1 || bus.res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_hold%0d mul=%b valid=%b want 1 0", i, bus.mul_en, bus.res_valid);
      end
      if (i == 3) begin
        bus.mul_done = 1'b1;
        bus.mul_result = 16'hFFEB;
      end else begin
        tick();
      end
    end
    tick();
    bus.mul_done = 1'b0;
    n_chk++;
    if (bus.mul_en !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_data !== 16'hFFEB || bus.res_flags !== 3'b000) begin
      n_fail++;
      $display("FAIL mul_emit mul=%b valid=%b data=%h flags=%b want 0 1 ffeb 000", bus.mul_en, bus.res_valid, bus.res_data, bus.res_flags);
    end
    tick();
    n_chk++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_done done=%b want 1", bus.done);
    end
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    mem[9] = w(4'd3, 8'h10, 8'h02);
    bus.first_addr = 5'd9;
    bus.last_addr  = 5'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    cnt = 0;
    while (bus.div_en === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    n_chk++;
    if (cnt !== 64) begin
      n_fail++;
      $display("FAIL div_timeout en_cycles=%0d want 64", cnt);
    end
    n_chk++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0000 || bus.res_flags !== 3'b001) begin
      n_fail++;
      $display("FAIL div_err valid=%b data=%h flags=%b want 1 0000 001", bus.res_valid, bus.res_data, bus.res_flags);
    end
    tick();
    tick();
  endtask

  task automatic test_wrap();
    logic [4:0]  ea [4];
    logic [15:0] ed [4];
    mem[30] = w(4'd0, 8'h01, 8'h01);
    mem[31] = w(4'd0, 8'h02, 8'h03);
    mem[0]  = w(4'd0, 8'h7F, 8'h00);
    mem[1]  = w(4'd1, 8'h00, 8'h01);
    ea = '{5'd30, 5'd31, 5'd0, 5'd1};
    ed = '{16'h0002, 16'h0005, 16'h007F, 16'hFFFF};
    run_window(5'd30, 5'd1);
    n_chk++;
    if (got_to !== 1'b0 || got_n !== 4 || got_done !== 1) begin
      n_fail++;
      $display("FAIL wrap_run timeout=%b words=%0d dones=%0d want 0 4 1", got_to, got_n, got_done);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (got_addr[i] !== ea[i] || got_data[i] !== ed[i] || got_flags[i] !== 3'b000) begin
        n_fail++;
        $display("FAIL wrap_w%0d addr=%0d data=%h flags=%b want %0d %h 000", i, got_addr[i], got_data[i], got_flags[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.first_addr = 5'd8;
    bus.last_addr  = 5'd8;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    n_chk++;
    if (bus.mul_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre mul=%b want 1", bus.mul_en);
    end
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (bus.mul_en !== 1'b0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async mul=%b busy=%b valid=%b done=%b want 0000", bus.mul_en, bus.busy, bus.res_valid, bus.done);
    end
    tick();
    #2 rst = 1'b1;
    bus.mul_done = 1'b1;
    bus.mul_result = 16'hFFEB;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.busy || bus.res_valid || bus.done || bus.mul_en) seen++;
    end
    bus.mul_done = 1'b0;
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL rmid_idle active_cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    mem[12] = w(4'd0, 8'h10, 8'h20);
    mem[13] = w(4'd1, 8'h03, 8'h05);
    run_window(5'd12, 5'd12);
    n_chk++;
    if (got_to !== 1'b0 || got_n !== 1 || got_data[0] !== 16'h0030 || got_addr[0] !== 5'd12) begin
      n_fail++;
      $display("FAIL b2b_first timeout=%b words=%0d data=%h addr=%0d want 0 1 0030 12", got_to, got_n, got_data[0], got_addr[0]);
    end
    run_window(5'd13, 5'd13);
    n_chk++;
    if (got_to !== 1'b0 || got_n !== 1 || got_data[0] !== 16'hFFFE || got_done !== 1) begin
      n_fail++;
      $display("FAIL b2b_second timeout=%b words=%0d data=%h dones=%0d want 0 1 fffe 1", got_to, got_n, got_data[0], got_done);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.first_addr = '0;
    bus.last_addr = '0;
    bus.mul_done = 1'b0;
    bus.div_done = 1'b0;
    bus.mul_result = '0;
    bus.div_result = '0;
    tick();
    tick();
    test_reset();
    #2 rst = 1'b1;
    tick();
    test_add_basic();
    test_flags();
    test_mul();
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
